conv3x3_shift_engine: RTL

- Parametrised 3x3 shift-weight convolution engine: streams a row-major image out of a synchronous single-port SRAM and produces one filtered pixel per output handshake.
- Each tap weight is a power of two (pixel >> shift), or zero. The 9 shift codes are loaded at run time, so one block covers Gaussian blur, identity and box-like kernels.
- Sits between the image SRAM and the downstream output buffer/writer, which takes results over a valid/ready interface.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_addr_gen.sv | 100 ++++++++++
 rtl/conv3x3_shift_engine.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 shift-weight convolution engine:
// FSM state encoding, shift-code constants and accumulator sizing.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ACC,
    OUT,
    DONE
  } conv_state_e;

  localparam logic [2:0] SH_QD   = 3'd2;
  localparam logic [2:0] SH_OC   = 3'd3;
  localparam logic [2:0] SH_HX   = 3'd4;
  localparam logic [2:0] SH_ZERO = 3'd7;

  // Tap t occupies bits [3t+2:3t]; the kernel is symmetric so order is moot.
  localparam logic [26:0] K_GAUSS = {SH_HX, SH_OC, SH_HX,
                                     SH_OC, SH_QD, SH_OC,
                                     SH_HX, SH_OC, SH_HX};

  localparam int unsigned ACC_GUARD = 4;
  localparam int unsigned N_TAPS    = 9;

endpackage

// File: rtl/conv_addr_gen.sv
// Row/col/tap counters for the 3x3 engine: border-validity decode of the
// current tap, its SRAM address, and the output pixel index.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int AW    = 20,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          tap_adv,
  input  logic          pix_adv,
  input  logic [AW-1:0] base,
  output logic [3:0]    tap,
  output logic          tap_valid,
  output logic [AW-1:0] tap_addr,
  output logic [AW-1:0] pix_idx,
  output logic          last_pixel
);

  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW+1:0] H_LIM    = (RW+2)'(IMG_H);
  localparam logic [CW+1:0] W_LIM    = (CW+2)'(IMG_W);
  localparam logic [3:0]    TAP_LAST = 4'(N_TAPS - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [3:0]    tap_q, tap_d;

  logic [1:0]    ro, co;
  logic [RW+1:0] rp, r_idx;
  logic [CW+1:0] cp, c_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      tap_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      tap_q <= tap_d;
    end
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    tap_d = tap_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
      tap_d = '0;
    end else begin
      if (tap_adv) begin
        tap_d = (tap_q == TAP_LAST) ? '0 : tap_q + 4'd1;
      end
      if (pix_adv) begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
  end

  // Offsets are carried biased by +1 so the border test stays unsigned:
  // position p+1 is inside the image when 1 <= p+1 <= limit.
  always_comb begin
    case (tap_q)
      4'd0, 4'd1, 4'd2: ro = 2'd0;
      4'd3, 4'd4, 4'd5: ro = 2'd1;
      default:          ro = 2'd2;
    endcase
    case (tap_q)
      4'd0, 4'd3, 4'd6: co = 2'd0;
      4'd1, 4'd4, 4'd7: co = 2'd1;
      default:          co = 2'd2;
    endcase
    rp    = {2'b00, row_q} + (RW+2)'(ro);
    cp    = {2'b00, col_q} + (CW+2)'(co);
    r_idx = rp - (RW+2)'(1);
    c_idx = cp - (CW+2)'(1);
  end

  assign tap       = tap_q;
  assign tap_valid = (rp != '0) && (rp <= H_LIM) && (cp != '0) && (cp <= W_LIM);
  assign tap_addr  = base + AW'(r_idx) * AW'(IMG_W) + AW'(c_idx);
  assign pix_idx   = AW'(row_q) * AW'(IMG_W) + AW'(col_q);
  assign last_pixel = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/conv3x3_shift_engine.sv
// 3x3 shift-weight convolution engine: FSM, accumulator and output register.
// Optional half-up rounding of each tap is enabled by defining CONV_ROUND_EN.
module conv3x3_shift_engine
  import conv_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 20,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [26:0]   k_shift,
  input  logic [AW-1:0] base_addr,
  output logic          busy,
  output logic          done,
  output logic          mem_csn,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr
);

  localparam int ACCW = DW + ACC_GUARD;

  conv_state_e   state_q, state_d;
  logic [26:0]   k_q, k_d;
  logic [AW-1:0] base_q, base_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic          prv_vld_q, prv_vld_d;
  logic [2:0]    prv_code_q, prv_code_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_addr_q, out_addr_d;

  logic          ag_clr, ag_tap_adv, ag_pix_adv;
  logic [3:0]    tap;
  logic          tap_in, last_pixel;
  logic [AW-1:0] tap_addr, pix_idx;

  logic [2:0]    tap_code;
  logic          rd_en;
  logic [DW-1:0] contrib;
  logic [ACCW-1:0] acc_add;

  conv_addr_gen #(
    .AW    (AW),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clr        (ag_clr),
    .tap_adv    (ag_tap_adv),
    .pix_adv    (ag_pix_adv),
    .base       (base_q),
    .tap        (tap),
    .tap_valid  (tap_in),
    .tap_addr   (tap_addr),
    .pix_idx    (pix_idx),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      base_q     <= '0;
      acc_q      <= '0;
      prv_vld_q  <= 1'b0;
      prv_code_q <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      base_q     <= base_d;
      acc_q      <= acc_d;
      prv_vld_q  <= prv_vld_d;
      prv_code_q <= prv_code_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
    end
  end

  always_comb begin
    tap_code = SH_ZERO;
    for (int unsigned i = 0; i < N_TAPS; i++) begin
      if (tap == 4'(i)) tap_code = k_q[3*i +: 3];
    end
  end

  assign rd_en    = (state_q == FETCH) && tap_in && (tap_code != SH_ZERO);
  assign mem_csn  = ~rd_en;
  assign mem_addr = rd_en ? tap_addr : '0;

  // Data for the tap read last cycle arrives now; its code travels alongside.
`ifdef CONV_ROUND_EN
  logic [DW:0] rnd, rsum;
  always_comb begin
    rnd = '0;
    if (prv_code_q != 3'd0 && prv_code_q != SH_ZERO) begin
      rnd = (DW+1)'(1) << (prv_code_q - 3'd1);
    end
    rsum    = {1'b0, mem_rdata} + rnd;
    contrib = DW'(rsum >> prv_code_q);
  end
`else
  assign contrib = mem_rdata >> prv_code_q;
`endif

  assign acc_add = prv_vld_q ? ACCW'(contrib) : '0;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    base_d     = base_q;
    acc_d      = acc_q + acc_add;
    prv_vld_d  = rd_en;
    prv_code_d = tap_code;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    ag_clr     = 1'b0;
    ag_tap_adv = 1'b0;
    ag_pix_adv = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          k_d     = k_shift;
          base_d  = base_addr;
          acc_d   = '0;
          ag_clr  = 1'b1;
        end
      end
      FETCH: begin
        ag_tap_adv = 1'b1;
        if (tap == 4'(N_TAPS - 1)) state_d = ACC;
      end
      ACC: begin
        state_d    = OUT;
        out_data_d = (acc_d[ACCW-1:DW] != '0) ? '1 : acc_d[DW-1:0];
        out_addr_d = pix_idx;
      end
      OUT: begin
        if (out_ready) begin
          ag_pix_adv = 1'b1;
          acc_d      = '0;
          out_data_d = '0;
          out_addr_d = '0;
          state_d    = last_pixel ? DONE : FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == FETCH) || (state_q == ACC) || (state_q == OUT);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;

endmodule
